// File: rtl/gam_learning_scheduler.sv
// Phase sequencer for the GAM memory layer: paced training epochs, associative
// learning hand-off, then single-request recall service under a handshake watchdog.
package gam_learning_scheduler_pkg;
    typedef enum logic { RW_WAIT = 1'b0, RW_READY = 1'b1 } ready_wait_t;
    typedef enum logic { LR_LEARNING = 1'b0, LR_RECALL = 1'b1 } learning_recall_t;
endpackage

module gam_learning_scheduler
    import gam_learning_scheduler_pkg::*;
#(
    parameter int NUM_SAMPLES    = 16,
    parameter int SAMPLE_ADDR_W  = 4,
    parameter int NUM_EPOCHS     = 4,
    parameter int EPOCH_W        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  ready_wait_t              ready_wait,
    input  logic                     ml_idle,
    output logic                     learning_done,
    output learning_recall_t         learning_recall,
    output logic                     sample_valid,
    output logic [SAMPLE_ADDR_W-1:0] sample_addr,
    output logic [EPOCH_W-1:0]       epoch,
    output logic                     assoc_learning_start,
    input  logic                     assoc_learning_done,
    input  logic                     recall_req,
    input  logic [SAMPLE_ADDR_W-1:0] recall_addr,
    output logic                     recall_ack,
    input  logic                     recall_done,
    output logic                     busy,
    output logic                     error
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SAMPLE_ADDR_W-1:0] LAST_SAMPLE = SAMPLE_ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0]       LAST_EPOCH  = EPOCH_W'(NUM_EPOCHS - 1);
    localparam logic [WD_W-1:0]          WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, WAIT_READY, HOLD, ADVANCE, DRAIN,
        ASSOC_START, ASSOC_WAIT, R_IDLE, R_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [SAMPLE_ADDR_W-1:0] addr_q, addr_d;
    logic [EPOCH_W-1:0]       epoch_q, epoch_d;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic                     err_q, err_d;
    logic                     ack_q, ack_d;
    logic                     idle_seen_q, idle_seen_d;
    logic                     last_sample;
    logic                     waiting;

    assign last_sample = (addr_q == LAST_SAMPLE) && (epoch_q == LAST_EPOCH);
    assign waiting = (state_q == WAIT_READY) || (state_q == DRAIN) ||
                     (state_q == ASSOC_WAIT) || (state_q == R_WAIT);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        epoch_d     = epoch_q;
        err_d       = err_q;
        ack_d       = 1'b0;
        idle_seen_d = 1'b0;
        wd_d        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    epoch_d = '0;
                    err_d   = 1'b0;
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: if (ready_wait == RW_READY) state_d = HOLD;
            HOLD:       state_d = last_sample ? DRAIN : ADVANCE;
            ADVANCE: begin
                state_d = WAIT_READY;
                if (addr_q == LAST_SAMPLE) begin
                    addr_d  = '0;
                    epoch_d = epoch_q + 1'b1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // idle must be seen on two back-to-back drain cycles
                idle_seen_d = ml_idle;
                if (ml_idle && idle_seen_q) state_d = ASSOC_START;
            end
            ASSOC_START: state_d = ASSOC_WAIT;
            ASSOC_WAIT:  if (assoc_learning_done) state_d = R_IDLE;
            R_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    epoch_d = '0;
                    err_d   = 1'b0;
                    state_d = WAIT_READY;
                end else if (recall_req) begin
                    addr_d  = recall_addr;
                    ack_d   = 1'b1;
                    state_d = R_WAIT;
                end
            end
            R_WAIT:  if (recall_done) state_d = R_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A completed handshake wins over a timeout landing on the same cycle.
        if (waiting && (state_d == state_q)) begin
            if (wd_q == WD_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            epoch_q     <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            idle_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            epoch_q     <= epoch_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            idle_seen_q <= idle_seen_d;
        end
    end

    always_comb begin
        learning_done = 1'b1;
        case (state_q)
            WAIT_READY, ADVANCE: learning_done = 1'b0;
            HOLD:                learning_done = last_sample;
            default:             learning_done = 1'b1;
        endcase
    end

    assign learning_recall = ((state_q == R_IDLE) || (state_q == R_WAIT)) ? LR_RECALL : LR_LEARNING;
    assign sample_valid    = (state_q == WAIT_READY) || (state_q == HOLD) || (state_q == R_WAIT);
    assign sample_addr     = addr_q;
    assign epoch           = epoch_q;
    assign assoc_learning_start = (state_q == ASSOC_START);
    assign recall_ack      = ack_q;
    assign busy            = (state_q != S_IDLE) && (state_q != R_IDLE);
    assign error           = err_q;
endmodule

// File: tb/tb_gam_learning_scheduler.sv
// Bench for gam_learning_scheduler: directed recall/priority table, watchdog and
// reset corners, randomized sessions against an epoch/sample sequence model.
module tb_gam_learning_scheduler;
    import gam_learning_scheduler_pkg::*;

    localparam int NS = 4;
    localparam int NE = 2;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    ready_wait_t      ready_wait = RW_WAIT;
    logic             ml_idle = 1'b0;
    logic             learning_done;
    learning_recall_t learning_recall;
    logic             sample_valid;
    logic [3:0]       sample_addr;
    logic [2:0]       epoch;
    logic             assoc_learning_start;
    logic             assoc_learning_done = 1'b0;
    logic             recall_req = 1'b0;
    logic [3:0]       recall_addr = '0;
    logic             recall_ack;
    logic             recall_done = 1'b0;
    logic             busy;
    logic             error;

    // single-sample instance
    logic             u1_start = 1'b0;
    ready_wait_t      u1_rw = RW_WAIT;
    logic             u1_ld, u1_valid, u1_assoc, u1_ack, u1_busy, u1_err;
    learning_recall_t u1_lr;
    logic [3:0]       u1_addr;
    logic [2:0]       u1_epoch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gam_learning_scheduler #(.NUM_SAMPLES(NS), .SAMPLE_ADDR_W(4), .NUM_EPOCHS(NE),
                             .EPOCH_W(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .ready_wait(ready_wait),
        .ml_idle(ml_idle), .learning_done(learning_done),
        .learning_recall(learning_recall), .sample_valid(sample_valid),
        .sample_addr(sample_addr), .epoch(epoch),
        .assoc_learning_start(assoc_learning_start),
        .assoc_learning_done(assoc_learning_done), .recall_req(recall_req),
        .recall_addr(recall_addr), .recall_ack(recall_ack),
        .recall_done(recall_done), .busy(busy), .error(error));

    gam_learning_scheduler #(.NUM_SAMPLES(1), .SAMPLE_ADDR_W(4), .NUM_EPOCHS(2),
                             .EPOCH_W(3), .TIMEOUT_CYCLES(TO)) u1 (
        .clk(clk), .reset(reset), .start(u1_start), .ready_wait(u1_rw),
        .ml_idle(1'b0), .learning_done(u1_ld), .learning_recall(u1_lr),
        .sample_valid(u1_valid), .sample_addr(u1_addr), .epoch(u1_epoch),
        .assoc_learning_start(u1_assoc), .assoc_learning_done(1'b0),
        .recall_req(1'b0), .recall_addr(4'd0), .recall_ack(u1_ack),
        .recall_done(1'b0), .busy(u1_busy), .error(u1_err));

    typedef struct {
        logic       st, req;
        logic [3:0] ra;
        logic       rd;
        logic       e_ack, e_valid;
        logic [3:0] e_addr;
        logic [2:0] e_epoch;
        logic       e_lr, e_busy;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Walks every (epoch, sample) pair in order with random READY latency.
    task automatic learn(input int abort_epoch, output bit aborted);
        int  w;
        bit  last;
        aborted = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_error", error, 0);
        for (int e = 0; e < NE; e++) begin
            for (int s = 0; s < NS; s++) begin
                w    = $urandom_range(0, 4);
                last = (e == NE - 1) && (s == NS - 1);
                for (int k = 0; k <= w; k++) begin
                    chk("wr_valid", sample_valid, 1);
                    chk("wr_addr", sample_addr, s);
                    chk("wr_epoch", epoch, e);
                    chk("wr_ldone", learning_done, 0);
                    chk("wr_mode", learning_recall, LR_LEARNING);
                    chk("wr_busy", busy, 1);
                    ready_wait = (k == w) ? RW_READY : RW_WAIT;
                    step();
                end
                ready_wait = RW_WAIT;
                chk("hold_valid", sample_valid, 1);
                chk("hold_addr", sample_addr, s);
                chk("hold_epoch", epoch, e);
                chk("hold_ldone", learning_done, last);
                start = 1'($urandom_range(0, 1));
                step();
                start = 1'b0;
                if (!last) begin
                    chk("adv_valid", sample_valid, 0);
                    chk("adv_ldone", learning_done, 0);
                    chk("adv_busy", busy, 1);
                    if (e == abort_epoch) begin
                        aborted = 1'b1;
                        return;
                    end
                    step();
                end
            end
        end
    endtask

    // From the first DRAIN cycle through associative learning into R_IDLE.
    task automatic drain_assoc();
        bit prev, got;
        int w;
        prev = 1'b0;
        got  = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            chk("drain_ldone", learning_done, 1);
            chk("drain_valid", sample_valid, 0);
            chk("drain_busy", busy, 1);
            chk("drain_astart", assoc_learning_start, 0);
            ml_idle = (n >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
            got  = prev && ml_idle;
            prev = ml_idle;
            step();
        end
        ml_idle = 1'b0;
        chk("astart_pulse", assoc_learning_start, 1);
        step();
        chk("astart_single", assoc_learning_start, 0);
        w = $urandom_range(0, 3);
        for (int k = 0; k < w; k++) begin
            chk("await_busy", busy, 1);
            chk("await_mode", learning_recall, LR_LEARNING);
            step();
        end
        assoc_learning_done = 1'b1;
        step();
        assoc_learning_done = 1'b0;
        chk("ridle_mode", learning_recall, LR_RECALL);
        chk("ridle_busy", busy, 0);
        chk("ridle_ldone", learning_done, 1);
    endtask

    task automatic recall(input logic [3:0] a, input int lat);
        recall_req  = 1'b1;
        recall_addr = a;
        step();
        for (int k = 0; k <= lat; k++) begin
            chk("rc_ack", recall_ack, (k == 0));
            chk("rc_addr", sample_addr, a);
            chk("rc_valid", sample_valid, 1);
            chk("rc_busy", busy, 1);
            recall_req  = 1'($urandom_range(0, 1));
            recall_addr = 4'($urandom);
            recall_done = (k == lat);
            step();
        end
        recall_req  = 1'b0;
        recall_done = 1'b0;
        chk("rc_back_busy", busy, 0);
        chk("rc_back_valid", sample_valid, 0);
        chk("rc_back_ack", recall_ack, 0);
        chk("rc_back_addr", sample_addr, a);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ab;
        tbl[0] = '{1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd3, 3'd1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 3'd1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 3'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 4'd9, 3'd1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd9, 3'd1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 3'd1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 3'd1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b1};

        step();
        chk("rst_ldone", learning_done, 1);
        chk("rst_mode", learning_recall, LR_LEARNING);
        chk("rst_valid", sample_valid, 0);
        chk("rst_addr", sample_addr, 0);
        chk("rst_epoch", epoch, 0);
        chk("rst_astart", assoc_learning_start, 0);
        chk("rst_ack", recall_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        step();
        reset = 1'b1;
        step();

        learn(-1, ab);
        drain_assoc();
        chk("post_learn_epoch", epoch, NE - 1);

        foreach (tbl[i]) begin
            start       = tbl[i].st;
            recall_req  = tbl[i].req;
            recall_addr = tbl[i].ra;
            recall_done = tbl[i].rd;
            step();
            start       = 1'b0;
            recall_req  = 1'b0;
            recall_done = 1'b0;
            chk($sformatf("tbl%0d_ack", i), recall_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_valid", i), sample_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_addr", i), sample_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_epoch", i), epoch, tbl[i].e_epoch);
            chk($sformatf("tbl%0d_mode", i), learning_recall, tbl[i].e_lr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Now in the first WAIT_READY cycle with ready_wait held at WAIT.
        repeat (TO - 1) step();
        chk("wd_edge_busy", busy, 1);
        chk("wd_edge_error", error, 0);
        step();
        chk("wd_error", error, 1);
        chk("wd_ldone", learning_done, 1);
        chk("wd_busy", busy, 0);
        chk("wd_valid", sample_valid, 0);

        learn(1, ab);
        reset = 1'b0;
        #2;
        chk("arst_ldone", learning_done, 1);
        chk("arst_valid", sample_valid, 0);
        chk("arst_addr", sample_addr, 0);
        chk("arst_epoch", epoch, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mode", learning_recall, LR_LEARNING);
        step();
        reset = 1'b1;
        step();
        chk("arst_idle_busy", busy, 0);

        for (int r = 0; r < 3; r++) begin
            learn(-1, ab);
            drain_assoc();
            repeat (3) recall(4'($urandom), $urandom_range(0, 3));
        end

        u1_start = 1'b1;
        step();
        u1_start = 1'b0;
        chk("ns1_e0_addr", u1_addr, 0);
        chk("ns1_e0_epoch", u1_epoch, 0);
        chk("ns1_e0_ldone", u1_ld, 0);
        u1_rw = RW_READY;
        step();
        u1_rw = RW_WAIT;
        chk("ns1_hold0_ldone", u1_ld, 0);
        step();
        chk("ns1_adv_valid", u1_valid, 0);
        step();
        chk("ns1_e1_addr", u1_addr, 0);
        chk("ns1_e1_epoch", u1_epoch, 1);
        chk("ns1_e1_valid", u1_valid, 1);
        u1_rw = RW_READY;
        step();
        u1_rw = RW_WAIT;
        chk("ns1_hold1_ldone", u1_ld, 1);
        step();
        chk("ns1_drain_busy", u1_busy, 1);
        chk("ns1_drain_valid", u1_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gam_learning_scheduler.md
Name: gam_learning_scheduler

Overview:
- Top-level phase sequencer for the GAM memory layer.
- Walks the training set through the memory layer controller for NUM_EPOCHS passes, using its READY/WAIT handshake to pace samples.
- Then runs associative-layer learning, then switches the system to recall mode and serves single recall requests.
- Includes a watchdog that traps hung handshakes.

Parameters:
- NUM_SAMPLES, 16, training samples per epoch (1..2^SAMPLE_ADDR_W).
- SAMPLE_ADDR_W, 4, width of sample index.
- NUM_EPOCHS, 4, learning passes (1..2^EPOCH_W).
- EPOCH_W, 3, width of epoch counter.
- TIMEOUT_CYCLES, 255, maximum wait cycles in any waiting state (>=4).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- start  input  1  one-cycle pulse; begin a learning session.
- ready_wait  input  READY_WAIT_T  handshake from the memory layer controller.
- ml_idle  input  1  high while the memory layer controller is in its idle state.
- learning_done  output  1  holds the memory layer controller in idle when high.
- learning_recall  output  LEARNING_RECALL_T  system mode.
- sample_valid  output  1  sample_addr is valid for the datapath.
- sample_addr  output  SAMPLE_ADDR_W  training/recall sample index.
- epoch  output  EPOCH_W  current epoch.
- assoc_learning_start  output  1  one-cycle pulse to the associative layer.
- assoc_learning_done  input  1  level; associative learning complete.
- recall_req  input  1  recall request.
- recall_addr  input  SAMPLE_ADDR_W  recall sample index.
- recall_ack  output  1  one-cycle accept pulse.
- recall_done  input  1  recall datapath finished.
- busy  output  1  high in every state except S_IDLE and R_IDLE.
- error  output  1  sticky watchdog flag.

Behaviour:
- Reset values: learning_done=1, learning_recall=LEARNING, sample_valid=0, sample_addr=0, epoch=0, assoc_learning_start=0, recall_ack=0, busy=0, error=0, state=S_IDLE, watchdog=0.
- All outputs are registered or pure state decode; no input-to-output combinational path.

States and transitions:
- S_IDLE: learning_done=1. On start: clear sample_addr and epoch, clear error, go to WAIT_READY.
- WAIT_READY: learning_done=0, sample_valid=1. When ready_wait==READY, go to HOLD.
- HOLD: exactly 1 cycle; sample_valid=1 and sample_addr unchanged. This keeps the sample stable through the controller's new_input cycle.
- HOLD exit, normal case: go to ADVANCE.
- HOLD exit, last sample of last epoch (sample_addr==NUM_SAMPLES-1 and epoch==NUM_EPOCHS-1): set learning_done=1 in the same cycle and go to DRAIN.
- ADVANCE: 1 cycle, sample_valid=0. sample_addr increments. On sample_addr==NUM_SAMPLES-1 it wraps to 0 and epoch increments. Then go to WAIT_READY.
- DRAIN: learning_done=1. When ml_idle is high for 2 consecutive cycles, go to ASSOC_START.
- ASSOC_START: assoc_learning_start=1 for 1 cycle, then go to ASSOC_WAIT.
- ASSOC_WAIT: when assoc_learning_done==1, go to R_IDLE.
- R_IDLE: learning_recall=RECALL, learning_done=1.
  - If recall_req: latch recall_addr into sample_addr, pulse recall_ack, go to R_WAIT.
  - start has priority over recall_req in the same cycle: reinitialise as from S_IDLE, learning_recall=LEARNING next cycle, no recall_ack.
- R_WAIT: sample_valid=1. When recall_done, go to R_IDLE.

Watchdog:
- Counts while in WAIT_READY, DRAIN, ASSOC_WAIT or R_WAIT; clears on any state change.
- When the count reaches TIMEOUT_CYCLES: error=1, learning_done=1, go to S_IDLE.
- error is cleared only by reset or an accepted start.

Boundary rules:
- start is ignored in every state except S_IDLE and R_IDLE.
- recall_req is ignored outside R_IDLE.
- reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous).
- NUM_SAMPLES=1: sample_addr stays 0 and epoch still advances.

Test Plan:
- NUM_SAMPLES=4, NUM_EPOCHS=2; start, then READY for 1 cycle after each sample -> sample_addr sequence 0,1,2,3,0,1,2,3; epoch 0→1 at the wrap; sample_addr stable during the cycle after each READY; learning_done rises in the HOLD of the 8th sample.
- After the last sample, ml_idle=1 for 2 cycles -> assoc_learning_start is a single-cycle pulse exactly 1 cycle later. assoc_learning_done=1 -> learning_recall=RECALL next cycle, busy=0.
- In R_IDLE: recall_req=1, recall_addr=3 -> recall_ack pulses, sample_addr=3, sample_valid=1 until recall_done, then back to R_IDLE.
- TIMEOUT_CYCLES=64; start with ready_wait held at WAIT -> error=1 after 64 cycles in WAIT_READY, state S_IDLE, learning_done=1. A new start clears error.
- In R_IDLE: start and recall_req in the same cycle -> no recall_ack, learning_recall=LEARNING, sample_addr=0, epoch=0.
- Assert reset during ADVANCE of epoch 1 -> all outputs at reset values before the next clock edge; start pulses during HOLD are ignored (no counter change).
